// File: rtl/canny_pkg.sv
// Shared types and default geometry for the canny line-buffer fetch path.
package canny_pkg;

  localparam int DEF_ADDR_W    = 20;
  localparam int DEF_ROW_WORDS = 256;
  localparam int DEF_WIN_ROWS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef logic [2:0] tap_t;

endpackage

// File: rtl/canny_addr_gen.sv
// Column base register with end-of-row skip, and per-tap row-offset address.
module canny_addr_gen
  import canny_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int ROW_WORDS  = DEF_ROW_WORDS,
  parameter int START_ADDR = 768,
  parameter int ROW_SKIP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_advance,
  input  tap_t              i_tap,
  output logic [7:0]        o_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W:0]   o_next_base
);

  localparam int              ROW_SH    = $clog2(ROW_WORDS);
  localparam logic [ADDR_W-1:0] START_V = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W:0] ROW_MASK  = (ADDR_W+1)'(ROW_WORDS - 1);
  localparam logic [ADDR_W:0] SKIP_STEP = (ADDR_W+1)'(ROW_SKIP * ROW_WORDS);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   w_base_x;
  logic              w_eor;

  assign w_base_x    = {1'b0, r_base};
  assign w_eor       = (w_base_x & ROW_MASK) == ROW_MASK;
  // One extra bit so a frame ending at the top of the address space still compares correctly.
  assign o_next_base = w_eor ? (w_base_x + ONE + SKIP_STEP) : (w_base_x + ONE);
  assign o_addr      = r_base - (ADDR_W'(i_tap) << ROW_SH);
  assign o_col       = r_base[7:0];

  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_base <= START_V;
    end else if (i_advance) begin
      r_base <= o_next_base[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/canny_row_fetch_sched.sv
// Read-address scheduler for the canny line-buffer fetch: WIN_ROWS taps per column.
// Optional counters o_stall_cycles / o_cols_done when CANNY_SCHED_STATS_EN is defined.
module canny_row_fetch_sched
  import canny_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int ROW_WORDS  = DEF_ROW_WORDS,
  parameter int WIN_ROWS   = DEF_WIN_ROWS,
  parameter int START_ADDR = 768,
  parameter int END_ADDR   = 65535,
  parameter int ROW_SKIP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stall,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  output logic              o_rd_valid,
  output logic [2:0]        o_rd_tap,
  output logic [7:0]        o_col_pos,
  output logic              o_col_last,
  output logic              o_busy,
  output logic              o_frame_done
`ifdef CANNY_SCHED_STATS_EN
  ,
  output logic [31:0]       o_stall_cycles,
  output logic [23:0]       o_cols_done
`endif
);

  localparam tap_t            TAP_LAST = tap_t'(WIN_ROWS - 1);
  localparam logic [ADDR_W:0] END_V    = (ADDR_W+1)'(END_ADDR);

  sched_state_t      r_state, w_next_state;
  tap_t              r_tap;
  logic              w_issue, w_col_end, w_start_ok;
  logic [7:0]        w_col;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_next_base;
  logic              r_rd_valid, r_col_last;
  tap_t              r_rd_tap;
  logic [7:0]        r_col_pos;

  assign w_start_ok = (r_state == IDLE) && i_start;
  assign w_issue    = (r_state == FETCH) && !i_stall;
  assign w_col_end  = w_issue && (r_tap == TAP_LAST);

  canny_addr_gen #(
    .ADDR_W     (ADDR_W),
    .ROW_WORDS  (ROW_WORDS),
    .START_ADDR (START_ADDR),
    .ROW_SKIP   (ROW_SKIP)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_start_ok),
    .i_advance   (w_col_end),
    .i_tap       (r_tap),
    .o_col       (w_col),
    .o_addr      (w_addr),
    .o_next_base (w_next_base)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = FETCH;
      FETCH:   if (w_col_end && (w_next_base > END_V)) w_next_state = DRAIN;
      DRAIN:   w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_rd_en      = w_issue;
    o_rd_addr    = (r_state == FETCH) ? w_addr : '0;
    o_busy       = (r_state == FETCH) || (r_state == DRAIN);
    o_frame_done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_tap <= '0;
    end else if (w_issue) begin
      r_tap <= w_col_end ? tap_t'(0) : r_tap + tap_t'(1);
    end
  end

  // Tag pipeline matches the one-cycle SRAM read latency; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_tap   <= '0;
      r_col_pos  <= '0;
      r_col_last <= 1'b0;
    end else begin
      r_rd_valid <= w_issue;
      r_rd_tap   <= r_tap;
      r_col_pos  <= w_col;
      r_col_last <= (r_tap == TAP_LAST);
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_tap   = r_rd_tap;
  assign o_col_pos  = r_col_pos;
  assign o_col_last = r_col_last;

`ifdef CANNY_SCHED_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [23:0] r_cols_done;

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_stall_cycles <= '0;
      r_cols_done    <= '0;
    end else begin
      if ((r_state == FETCH) && i_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_col_end && (r_cols_done != '1))
        r_cols_done <= r_cols_done + 24'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_cols_done    = r_cols_done;
`endif

endmodule

// File: tb/tb_canny_row_fetch_sched.sv
// Directed bench for canny_row_fetch_sched: vector table plus multi-cycle corner sequences.
module tb_canny_row_fetch_sched;

  logic        clk;
  logic        reset, start, stall;
  logic [19:0] rd_addr;
  logic        rd_en, rd_valid, col_last, busy, frame_done;
  logic [2:0]  rd_tap;
  logic [7:0]  col_pos;

  logic        e_reset, e_start, e_stall;
  logic [19:0] e_rd_addr;
  logic        e_rd_en, e_rd_valid, e_col_last, e_busy, e_frame_done;
  logic [2:0]  e_rd_tap;
  logic [7:0]  e_col_pos;

`ifdef CANNY_SCHED_STATS_EN
  logic [31:0] stall_cycles, e_stall_cycles;
  logic [23:0] cols_done, e_cols_done;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  canny_row_fetch_sched dut (
    .clk(clk), .reset(reset), .i_start(start), .i_stall(stall),
    .o_rd_addr(rd_addr), .o_rd_en(rd_en), .o_rd_valid(rd_valid), .o_rd_tap(rd_tap),
    .o_col_pos(col_pos), .o_col_last(col_last), .o_busy(busy), .o_frame_done(frame_done)
`ifdef CANNY_SCHED_STATS_EN
    , .o_stall_cycles(stall_cycles), .o_cols_done(cols_done)
`endif
  );

  canny_row_fetch_sched #(.END_ADDR(770)) dut_end (
    .clk(clk), .reset(e_reset), .i_start(e_start), .i_stall(e_stall),
    .o_rd_addr(e_rd_addr), .o_rd_en(e_rd_en), .o_rd_valid(e_rd_valid), .o_rd_tap(e_rd_tap),
    .o_col_pos(e_col_pos), .o_col_last(e_col_last), .o_busy(e_busy), .o_frame_done(e_frame_done)
`ifdef CANNY_SCHED_STATS_EN
    , .o_stall_cycles(e_stall_cycles), .o_cols_done(e_cols_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic        stall;
    logic        en;
    logic [19:0] addr;
    logic        vld;
    logic [2:0]  tap;
    logic [7:0]  col;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t vt[13];
  logic [19:0] exp2[7];
  logic [19:0] q_addr[$];
  logic        vhist[60];
  logic        found;
  int          tlast, tfd, nfd;

  initial begin
    // start/stall | rd_en, rd_addr | rd_valid, rd_tap, col_pos, col_last | busy
    vt[0]  = '{1, 0, 0,   0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 1, 768, 0, 0, 0, 0, 1};
    vt[2]  = '{0, 0, 1, 512, 1, 0, 0, 0, 1};
    vt[3]  = '{0, 0, 1, 256, 1, 1, 0, 0, 1};
    vt[4]  = '{0, 0, 1,   0, 1, 2, 0, 0, 1};
    vt[5]  = '{0, 0, 1, 769, 1, 3, 0, 1, 1};
    vt[6]  = '{0, 0, 1, 513, 1, 0, 1, 0, 1};
    vt[7]  = '{0, 1, 0, 257, 1, 1, 1, 0, 1};
    vt[8]  = '{0, 1, 0, 257, 0, 0, 0, 0, 1};
    vt[9]  = '{0, 1, 0, 257, 0, 0, 0, 0, 1};
    vt[10] = '{0, 0, 1, 257, 0, 0, 0, 0, 1};
    vt[11] = '{0, 0, 1,   1, 1, 2, 1, 0, 1};
    vt[12] = '{0, 0, 1, 770, 1, 3, 1, 1, 1};
    exp2 = '{767, 511, 255, 1280, 1024, 768, 512};

    reset = 1; start = 0; stall = 0;
    e_reset = 1; e_start = 0; e_stall = 0;
    repeat (3) tick();
    reset = 0; e_reset = 0;

    // reset state, first frame start, stall at tap 2
    for (int i = 0; i < 13; i++) begin
      start = vt[i].start;
      stall = vt[i].stall;
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(vt[i].en));
      chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(vt[i].addr));
      chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].vld));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'd0);
      if (vt[i].vld) begin
        chk($sformatf("v%0d_rd_tap", i), 32'(rd_tap), 32'(vt[i].tap));
        chk($sformatf("v%0d_col_pos", i), 32'(col_pos), 32'(vt[i].col));
        chk($sformatf("v%0d_col_last", i), 32'(col_last), 32'(vt[i].last));
      end
      tick();
    end
    start = 0; stall = 0;
`ifdef CANNY_SCHED_STATS_EN
    chk("stats_stall_cycles", stall_cycles, 32'd3);
    chk("stats_cols_done", 32'(cols_done), 32'd2);
`endif

    // run to end of row: base 1023 then row-skip to 1280
    found = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 20'd1023) found = 1;
      else tick();
    end
    chk("reach_1023", 32'(found), 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("eor_en%0d", k), 32'(rd_en), 32'd1);
      chk($sformatf("eor_addr%0d", k), 32'(rd_addr), 32'(exp2[k]));
    end

    // reset mid-frame at tap 1 of column 1281
    found = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      tick();
      @(negedge clk);
      if (rd_en && rd_addr == 20'd1025) found = 1;
    end
    chk("reach_1025", 32'(found), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    nfd = 0;
    for (int c = 0; c < 6; c++) begin
      if (frame_done) nfd++;
      tick();
      @(negedge clk);
    end
    chk("rst_no_frame_done", 32'(nfd), 32'd0);

    // start and reset together: reset wins
    tick();
    start = 1; reset = 1;
    tick();
    start = 0; reset = 0;
    @(negedge clk);
    chk("start_reset_busy", 32'(busy), 32'd0);
    chk("start_reset_rd_en", 32'(rd_en), 32'd0);
    tick();
    start = 1;
    tick();
    start = 0;
    @(negedge clk);
    chk("restart_rd_en", 32'(rd_en), 32'd1);
    chk("restart_addr", 32'(rd_addr), 32'd768);
`ifdef CANNY_SCHED_STATS_EN
    chk("stats_clr_stall", stall_cycles, 32'd0);
    chk("stats_clr_cols", 32'(cols_done), 32'd0);
`endif

    // short frame ending at base 770
    tick();
    e_start = 1;
    tick();
    e_start = 0;
    tlast = -100; tfd = -200; nfd = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      vhist[c] = e_rd_valid;
      if (e_rd_en) q_addr.push_back(e_rd_addr);
      if (e_rd_en && e_rd_addr == 20'd2) tlast = c;
      if (e_frame_done) begin nfd++; tfd = c; end
      tick();
    end
    chk("end_nreads", 32'(q_addr.size()), 32'd12);
    if (q_addr.size() >= 4) begin
      chk("end_last0", 32'(q_addr[q_addr.size()-4]), 32'd770);
      chk("end_last1", 32'(q_addr[q_addr.size()-3]), 32'd514);
      chk("end_last2", 32'(q_addr[q_addr.size()-2]), 32'd258);
      chk("end_last3", 32'(q_addr[q_addr.size()-1]), 32'd2);
    end
    chk("end_fd_count", 32'(nfd), 32'd1);
    chk("end_fd_latency", 32'(tfd - tlast), 32'd2);
    if (tlast >= 0 && tlast < 59) chk("end_drain_valid", 32'(vhist[tlast+1]), 32'd1);
    chk("end_busy", 32'(e_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
